// File: rtl/input_conditioner_pkg.sv
// Shared types and default timing for the input conditioner.
// The default timing constants assume a 65 MHz system clock.
package input_conditioner_pkg;

  localparam int unsigned CLK_HZ              = 65_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY    = CLK_HZ / 2;    // 0.5 s
  localparam int unsigned DEF_REPEAT_PERIOD   = CLK_HZ / 10;   // 0.1 s

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Bits needed for a counter that runs 0 .. n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/input_conditioner_cond_channel.sv
// One conditioned input: 2-flop synchroniser, debounce counter, edge pulses
// and a press auto-repeat state machine. All outputs come straight from flops.
module cond_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clock,
  input  logic reset,
  input  logic noisy,
  input  logic repeat_en,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic press
);

  localparam int unsigned DB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RPT_W = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic             sync_meta_q;
  logic             sync_q;
  logic             stable_q;
  logic             stable_d;
  logic [DB_W-1:0]  db_cnt_q;
  logic [DB_W-1:0]  db_cnt_d;
  logic             clean_q;
  logic             rise_q;
  logic             fall_q;
  logic             press_q;
  logic             rise_d;
  logic             fall_d;
  logic             tick_d;
  rpt_state_e       state_q;
  logic [RPT_W-1:0] rpt_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_meta_q <= noisy;
      sync_q      <= sync_meta_q;
    end
  end

  // stable_q is the accepted level; clean_q trails it by one register so that
  // rise/fall can be produced in the same cycle clean shows the new value.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    if (sync_q != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = ~stable_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign rise_d = stable_q & ~clean_q;
  assign fall_d = ~stable_q & clean_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stable_q <= 1'b0;
      db_cnt_q <= '0;
      clean_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
      clean_q  <= stable_q;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  // A repeat tick is suppressed by a coincident fall or a dropped enable.
  always_comb begin
    tick_d = 1'b0;
    if (repeat_en && !fall_d) begin
      case (state_q)
        RPT_DELAY:  tick_d = (rpt_cnt_q == DLY_LAST);
        RPT_REPEAT: tick_d = (rpt_cnt_q == PER_LAST);
        default:    tick_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RPT_IDLE;
      rpt_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      press_q <= rise_d | tick_d;
      case (state_q)
        RPT_IDLE: begin
          rpt_cnt_q <= '0;
          if (rise_d && repeat_en) begin
            state_q <= RPT_DELAY;
          end
        end
        RPT_DELAY: begin
          if (fall_d || !repeat_en) begin
            state_q   <= RPT_IDLE;
            rpt_cnt_q <= '0;
          end else if (rpt_cnt_q == DLY_LAST) begin
            state_q   <= RPT_REPEAT;
            rpt_cnt_q <= '0;
          end else begin
            rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (fall_d || !repeat_en) begin
            state_q   <= RPT_IDLE;
            rpt_cnt_q <= '0;
          end else if (rpt_cnt_q == PER_LAST) begin
            rpt_cnt_q <= '0;
          end else begin
            rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
          end
        end
        default: begin
          state_q   <= RPT_IDLE;
          rpt_cnt_q <= '0;
        end
      endcase
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign press = press_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel button/switch conditioner: each bit of noisy is synchronised,
// debounced, edge-detected and given optional press auto-repeat independently.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned CHANNELS        = 5,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] press
);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      cond_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
        .clock     (clock),
        .reset     (reset),
        .noisy     (noisy[gi]),
        .repeat_en (repeat_en[gi]),
        .clean     (clean[gi]),
        .rise      (rise[gi]),
        .fall      (fall[gi]),
        .press     (press[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: a directed vector table, hand-written
// auto-repeat/reset sequences and a randomized run against a sample-history model.
module tb_input_conditioner;

  localparam int CH   = 2;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int HMAX = 4096;

  logic          clock = 1'b0;
  logic          reset;
  logic [CH-1:0] noisy;
  logic [CH-1:0] repeat_en;
  logic [CH-1:0] clean;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] press;

  input_conditioner #(
    .CHANNELS        (CH),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .noisy     (noisy),
    .repeat_en (repeat_en),
    .clean     (clean),
    .rise      (rise),
    .fall      (fall),
    .press     (press)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: every sample of noisy since reset release, indexed by edge.
  int            n_edge = -1;
  logic          hist [CH][HMAX];
  logic [CH-1:0] m_clean, m_rise, m_fall, m_press, m_active;
  int            m_t0 [CH];

  typedef struct {
    logic [CH-1:0] nz;
    logic [CH-1:0] en;
    logic          rst;
    logic [CH-1:0] c;
    logic [CH-1:0] r;
    logic [CH-1:0] f;
    logic [CH-1:0] p;
  } vec_t;

  vec_t tbl [20];

  task automatic chk_v(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, n_edge, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, n_edge, act, exp);
    end
  endtask

  function automatic logic samp(input int ch, input int i);
    if (i < 0) return 1'b0;
    return hist[ch][i];
  endfunction

  // Drive inputs, take one edge, advance the model, then check all outputs.
  task automatic step(input logic [CH-1:0] nz, input logic [CH-1:0] en, input logic rst);
    logic [CH-1:0] old;
    bit            all_new;
    int            k;
    noisy     = nz;
    repeat_en = en;
    reset     = rst;
    @(posedge clock);
    if (rst) begin
      n_edge   = -1;
      m_clean  = '0;
      m_rise   = '0;
      m_fall   = '0;
      m_press  = '0;
      m_active = '0;
    end else begin
      n_edge++;
      old = m_clean;
      for (int c = 0; c < CH; c++) begin
        if (n_edge < HMAX) hist[c][n_edge] = nz[c];
        // A new level is shown once the DB samples taken 3..DB+2 edges ago all agree on it.
        all_new = 1'b1;
        for (int i = n_edge - DB - 2; i <= n_edge - 3; i++) begin
          if (samp(c, i) == old[c]) all_new = 1'b0;
        end
        if (all_new) m_clean[c] = ~old[c];
        m_rise[c]  = m_clean[c] & ~old[c];
        m_fall[c]  = ~m_clean[c] & old[c];
        m_press[c] = m_rise[c];
        if (m_active[c]) begin
          k = n_edge - m_t0[c];
          if (m_fall[c] || !en[c]) m_active[c] = 1'b0;
          else if (k >= RD && ((k - RD) % RP) == 0) m_press[c] = 1'b1;
        end else if (m_rise[c] && en[c]) begin
          m_active[c] = 1'b1;
          m_t0[c]     = n_edge;
        end
      end
    end
    #1;
    chk_v("model_clean", clean, m_clean);
    chk_v("model_rise", rise, m_rise);
    chk_v("model_fall", fall, m_fall);
    chk_v("model_press", press, m_press);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) step('0, '0, 1'b1);
  endtask

  task automatic run_until_rise(input logic [CH-1:0] nz, input logic [CH-1:0] en,
                                input int ch, output int t);
    t = -1;
    for (int k = 0; k < 20 && t < 0; k++) begin
      step(nz, en, 1'b0);
      if (rise[ch]) t = n_edge;
    end
    chk_i("rise_found", (t >= 0) ? 1 : 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, rel, fe;
    logic [CH-1:0] nz, en;
    int flip_div;

    tbl[0]  = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[2]  = '{2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};  // edge 0
    tbl[3]  = '{2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[4]  = '{2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[5]  = '{2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[6]  = '{2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[7]  = '{2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};  // edge 5
    tbl[8]  = '{2'b01, 2'b00, 1'b0, 2'b01, 2'b01, 2'b00, 2'b01};  // edge 6
    tbl[9]  = '{2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00};
    tbl[10] = '{2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00};
    tbl[11] = '{2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00};  // edge 9
    tbl[12] = '{2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00};  // edge 10
    tbl[13] = '{2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00};
    tbl[14] = '{2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00};
    tbl[15] = '{2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00};
    tbl[16] = '{2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00};
    tbl[17] = '{2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00};  // edge 15
    tbl[18] = '{2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00};  // edge 16
    tbl[19] = '{2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].nz, tbl[i].en, tbl[i].rst);
      chk_v("tbl_clean", clean, tbl[i].c);
      chk_v("tbl_rise", rise, tbl[i].r);
      chk_v("tbl_fall", fall, tbl[i].f);
      chk_v("tbl_press", press, tbl[i].p);
    end

    // Bouncy input: 3 high, 1 low, five times -> never accepted.
    do_reset();
    for (int rep = 0; rep < 5; rep++) begin
      for (int j = 0; j < 4; j++) begin
        step((j < 3) ? 2'b01 : 2'b00, 2'b00, 1'b0);
        chk_i("bounce_clean", int'(clean[0]), 0);
        chk_i("bounce_rise", int'(rise[0]), 0);
      end
    end
    for (int j = 0; j < 8; j++) begin
      step(2'b00, 2'b00, 1'b0);
      chk_i("bounce_tail_clean", int'(clean[0]), 0);
    end

    // Auto-repeat on channel 1, then release.
    do_reset();
    run_until_rise(2'b10, 2'b10, 1, t);
    chk_i("rise_latency", t, 6);
    chk_i("press_at_rise", int'(press[1]), 1);
    while (n_edge < t + 17) begin
      step(2'b10, 2'b10, 1'b0);
      chk_i("repeat_press", int'(press[1]),
            (n_edge == t + 10 || n_edge == t + 13 || n_edge == t + 16) ? 1 : 0);
    end
    rel = n_edge + 1;
    fe  = -1;
    for (int k = 0; k < 12 && fe < 0; k++) begin
      step(2'b00, 2'b10, 1'b0);
      if (fall[1]) fe = n_edge;
    end
    chk_i("release_to_fall", fe - rel, 6);
    for (int k = 0; k < 10; k++) begin
      step(2'b00, 2'b10, 1'b0);
      chk_i("after_fall_press", int'(press[1]), 0);
    end

    // Dropping repeat_en during REPEAT stops ticks but keeps clean high.
    do_reset();
    run_until_rise(2'b10, 2'b10, 1, t);
    while (n_edge < t + 11) begin
      step(2'b10, 2'b10, 1'b0);
      chk_i("pre_drop_press", int'(press[1]), (n_edge == t + 10) ? 1 : 0);
    end
    while (n_edge < t + 25) begin
      step(2'b10, 2'b00, 1'b0);
      chk_i("dropped_en_press", int'(press[1]), 0);
      chk_i("dropped_en_clean", int'(clean[1]), 1);
    end

    // Reset in the middle of REPEAT discards everything.
    do_reset();
    run_until_rise(2'b10, 2'b10, 1, t);
    while (n_edge < t + 10) step(2'b10, 2'b10, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(2'b10, 2'b10, 1'b1);
      chk_i("reset_outputs", int'({clean, rise, fall, press}), 0);
    end
    run_until_rise(2'b10, 2'b10, 1, t2);
    chk_i("post_reset_latency", t2, 6);
    chk_i("post_reset_press", int'(press[1]), 1);
    chk_i("post_reset_clean", int'(clean[1]), 1);

    // Both channels pressed together must repeat in lockstep.
    do_reset();
    run_until_rise(2'b11, 2'b11, 0, t);
    chk_v("dual_rise", rise, 2'b11);
    for (int k = 0; k < 20; k++) begin
      step(2'b11, 2'b11, 1'b0);
      chk_i("dual_press_equal", int'(press[0]), int'(press[1]));
    end

    // Randomized run, alternating bouncy and calm phases.
    do_reset();
    nz = '0;
    en = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      flip_div = ((cyc / 400) % 2 == 0) ? 5 : 40;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, flip_div - 1) == 0) nz[c] = ~nz[c];
        if ($urandom_range(0, 59) == 0) en[c] = ~en[c];
      end
      step(nz, en, ($urandom_range(0, 699) == 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
